// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg : shared types and constants for the instruction-fetch stage.
//
// Contents
//   NOP_INSTR_DEFAULT : bubble instruction (sll $0,$0,0) used when nothing
//                       real occupies IF/ID.
//   fetch_state_e     : fetch FSM encoding (RUN = 1'b0, FAULT = 1'b1).
//   IFID_W            : width of the packed IF/ID bundle (97 bits).
//   ifid_t            : packed IF/ID bundle {valid, instr, pc, npc}.
//   ifid_bubble()     : helper that builds the bubble value of the bundle.
// -----------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    localparam int IFID_W = 97;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } ifid_t;

    // A bubble carries the NOP encoding but is marked invalid; its PC
    // fields are zeroed so a stray consumer never sees a stale address.
    function automatic ifid_t ifid_bubble(input logic [31:0] nop_instr);
        ifid_t b;
        b.valid = 1'b0;
        b.instr = nop_instr;
        b.pc    = 32'h0000_0000;
        b.npc   = 32'h0000_0000;
        return b;
    endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg : IF/ID pipeline register holding the packed fetch bundle.
//
// Parameters
//   NOP_INSTR : instruction encoding written on reset and on bubble.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (loads the bubble value)
//   hold_i   in   keep the current contents (highest priority)
//   bubble_i in   load the bubble value
//   load_i   in   load d_i
//   d_i      in   next bundle when load_i is taken
//   q_o      out  current bundle
//
// At most one of hold/bubble/load is expected per edge; if several are
// asserted the priority is hold > bubble > load. With none asserted the
// register keeps its value.
// -----------------------------------------------------------------------------
module ifid_reg
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              load_i,
    input  logic [IFID_W-1:0] d_i,
    output logic [IFID_W-1:0] q_o
);

    localparam ifid_t BUBBLE = ifid_bubble(NOP_INSTR);

    logic [IFID_W-1:0] bundle_q;
    logic [IFID_W-1:0] bundle_d;

    always_comb begin
        bundle_d = bundle_q;
        if (hold_i) begin
            bundle_d = bundle_q;
        end else if (bubble_i) begin
            bundle_d = BUBBLE;
        end else if (load_i) begin
            bundle_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= BUBBLE;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign q_o = bundle_q;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage : instruction-fetch stage of the pipelined MIPS core.
//
// Owns the program counter, presents a word index to an asynchronous-read
// instruction memory, and captures the returned word into IF/ID. Handles
// load-use stalls, branch/jump redirects (which squash the fetch slot) and
// out-of-range fetch faults.
//
// Parameters
//   RESET_PC   : byte address loaded into PC on reset (forced word-aligned)
//   IMEM_DEPTH : number of 32-bit words; word indices >= IMEM_DEPTH fault
//   NOP_INSTR  : bubble instruction written into IF/ID
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   stall        hold PC, IF/ID and FSM state
//   redirect     load PC from redirect_pc and squash the fetch slot
//   redirect_pc  byte target of the redirect (bits [1:0] ignored)
//   imem_addr    word index {2'b00, pc[31:2]} to instruction memory
//   imem_instr   instruction returned combinationally for imem_addr
//   pc           current PC (byte address)
//   ifid_instr, ifid_pc, ifid_npc, ifid_valid : IF/ID register contents
//   fetch_fault  high while the FSM is in FAULT; this is the FSM state
//                register itself, so it doubles as the state debug view
//
// Optional build macro IF_FETCH_STATS_EN adds stat_fetches / stat_bubbles
// event counters (32-bit, wrapping).
//
// Control semantics: stall and redirect are level-qualified per edge, not a
// handshake. Each rising edge resolves exactly one action in priority order
// redirect > stall > FAULT hold > range fault > normal fetch; the
// upstream/downstream logic never waits for an acknowledge.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        fetch_fault
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetches,
    output logic [31:0] stat_bubbles
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;
    localparam logic [31:0] DEPTH_WORDS      = 32'(IMEM_DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;

    // IF/ID control for this edge
    logic ifid_load, ifid_bubble, ifid_hold;

    logic        in_range;
    logic [31:0] pc_plus4;

    // Only the word part of a redirect target is meaningful.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign in_range  = ({2'b00, pc_q[31:2]} < DEPTH_WORDS);
    // Modulo-2^32: 0xFFFF_FFFC wraps to 0 silently; the range check is
    // what stops runaway fetch.
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = {2'b00, pc_q[31:2]};

    // -------------------------------------------------------------------------
    // Next-state / control
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_hold   = 1'b0;

        if (redirect) begin
            // Redirect wins over stall: the instruction in the fetch slot
            // is on the wrong path, so holding it would be incorrect.
            pc_d        = {redirect_pc[31:2], 2'b00};
            ifid_bubble = 1'b1;
            state_d     = ST_RUN;
        end else if (stall) begin
            ifid_hold   = 1'b1;
        end else if (state_q == ST_FAULT) begin
            ifid_bubble = 1'b1;
        end else if (!in_range) begin
            // An out-of-range target reached by redirect lands here one
            // edge after the redirect itself.
            state_d     = ST_FAULT;
            ifid_bubble = 1'b1;
        end else begin
            ifid_load   = 1'b1;
            pc_d        = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC_ALIGNED;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID register
    // -------------------------------------------------------------------------
    ifid_t fetch_bundle;
    ifid_t ifid_q;

    always_comb begin
        fetch_bundle.valid = 1'b1;
        fetch_bundle.instr = imem_instr;
        fetch_bundle.pc    = pc_q;
        fetch_bundle.npc   = pc_plus4;
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (ifid_hold),
        .bubble_i (ifid_bubble),
        .load_i   (ifid_load),
        .d_i      (fetch_bundle),
        .q_o      (ifid_q)
    );

    assign pc          = pc_q;
    assign ifid_instr  = ifid_q.instr;
    assign ifid_pc     = ifid_q.pc;
    assign ifid_npc    = ifid_q.npc;
    assign ifid_valid  = ifid_q.valid;
    assign fetch_fault = (state_q == ST_FAULT);

`ifdef IF_FETCH_STATS_EN
    // -------------------------------------------------------------------------
    // Event counters: a stall edge is neither a fetch nor a bubble.
    // -------------------------------------------------------------------------
    logic [31:0] stat_fetches_q, stat_fetches_d;
    logic [31:0] stat_bubbles_q, stat_bubbles_d;

    always_comb begin
        stat_fetches_d = stat_fetches_q;
        stat_bubbles_d = stat_bubbles_q;
        if (ifid_load) begin
            stat_fetches_d = stat_fetches_q + 32'd1;
        end
        if (ifid_bubble) begin
            stat_bubbles_d = stat_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetches_q <= 32'd0;
            stat_bubbles_q <= 32'd0;
        end else begin
            stat_fetches_q <= stat_fetches_d;
            stat_bubbles_q <= stat_bubbles_d;
        end
    end

    assign stat_fetches = stat_fetches_q;
    assign stat_bubbles = stat_bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage : self-checking bench for if_fetch_stage.
// Directed scenarios followed by a randomized stall/redirect phase whose
// expected IF/ID results go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam int DEPTH = 64;
  localparam int SB_W  = 130; // {fault, pc, valid, instr, ifid_pc, ifid_npc}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        fetch_fault;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] stat_fetches;
  logic [31:0] stat_bubbles;
`endif

  logic [31:0] mem [DEPTH];

  assign imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[5:0]] : 32'hDEAD_BEEF;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (DEPTH),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_npc    (ifid_npc),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault)
`ifdef IF_FETCH_STATS_EN
    ,
    .stat_fetches (stat_fetches),
    .stat_bubbles (stat_bubbles)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [SB_W-1:0] got,
                       input logic [SB_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard for the random phase
  // ---------------------------------------------------------------------------
  logic [SB_W-1:0] exp_q[$];
  logic [31:0]     m_pc;
  logic            m_fault;
  logic [96:0]     m_ifid;

  function automatic logic [31:0] mem_read(input logic [31:0] byte_pc);
    logic [31:0] w;
    w = {2'b00, byte_pc[31:2]};
    return (w < 32'(DEPTH)) ? mem[w[5:0]] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc);
    if (r) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_ifid  = {1'b0, 32'h0, 32'h0, 32'h0};
      m_fault = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_fault) begin
      m_ifid  = {1'b0, 32'h0, 32'h0, 32'h0};
    end else if (m_pc[31:2] >= 30'(DEPTH)) begin
      m_fault = 1'b1;
      m_ifid  = {1'b0, 32'h0, 32'h0, 32'h0};
    end else begin
      m_ifid  = {1'b1, mem_read(m_pc), m_pc, m_pc + 32'd4};
      m_pc    = m_pc + 32'd4;
    end
    exp_q.push_back({m_fault, m_pc, m_ifid});
  endtask

  function automatic logic [SB_W-1:0] observed();
    return {fetch_fault, pc, ifid_valid, ifid_instr, ifid_pc, ifid_npc};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0007;
    mem[2] = 32'h0022_1820;
    mem[3] = 32'hAC03_0000;
    for (int i = 4; i < DEPTH; i++) mem[i] = 32'h1000_0000 | i | ($urandom_range(255, 1) << 8);

    // Reset state
    #3;
    check("rst_pc",    pc,          0);
    check("rst_valid", ifid_valid,  0);
    check("rst_instr", ifid_instr,  0);
    check("rst_ipc",   ifid_pc,     0);
    check("rst_npc",   ifid_npc,    0);
    check("rst_fault", fetch_fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First fetch
    step();
    check("f1_instr", ifid_instr, 32'h2001_0005);
    check("f1_ipc",   ifid_pc,    0);
    check("f1_npc",   ifid_npc,   4);
    check("f1_valid", ifid_valid, 1);
    check("f1_pc",    pc,         4);

    // Stall at pc=8
    step();
    check("pc_8", pc, 8);
    drive(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc",    pc,         8);
      check("stall_instr", ifid_instr, 32'h2002_0007);
      check("stall_ipc",   ifid_pc,    4);
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("unstall_instr", ifid_instr, 32'h0022_1820);
    step();
    check("pc_10", pc, 32'h10);

    // Redirect with simultaneous stall
    drive(1'b1, 1'b1, 32'h0000_0013);
    step();
    check("rd_pc",    pc,         32'h10);
    check("rd_valid", ifid_valid, 0);
    check("rd_instr", ifid_instr, 0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("rd_fetch_instr", ifid_instr, mem[4]);
    check("rd_fetch_ipc",   ifid_pc,    32'h10);

    // Range fault at word 64
    drive(1'b0, 1'b1, 32'h0000_00F8);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    check("edge_instr", ifid_instr, mem[63]);
    check("edge_pc",    pc,         32'h100);
    check("edge_fault", fetch_fault, 0);
    step();
    check("flt_fault", fetch_fault, 1);
    check("flt_pc",    pc,          32'h100);
    check("flt_valid", ifid_valid,  0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("flt_hold_fault", fetch_fault, 1);
      check("flt_hold_pc",    pc,          32'h100);
    end
    drive(1'b0, 1'b1, 32'h0000_0008);
    step();
    check("clr_fault", fetch_fault, 0);
    check("clr_pc",    pc,          8);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("clr_instr", ifid_instr, 32'h0022_1820);
    check("clr_ipc",   ifid_pc,    8);

    // Redirect out of range: RUN first, FAULT one edge later
    drive(1'b0, 1'b1, 32'h0000_0400);
    step();
    check("oor_rd_fault", fetch_fault, 0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("oor_fault", fetch_fault, 1);

    // Async reset between edges while faulted
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",    pc,          0);
    check("arst_valid", ifid_valid,  0);
    check("arst_fault", fetch_fault, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("arst_resume_instr", ifid_instr, 32'h2001_0005);
    check("arst_resume_pc",    pc,         4);

`ifdef IF_FETCH_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) step();
    drive(1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b0, 1'b1, 32'h0000_0000);
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("stat_fetches", stat_fetches, 10);
    check("stat_bubbles", stat_bubbles, 1);
`endif

    // Randomized phase through the scoreboard
    do_reset();
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_ifid  = {1'b0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 300; i++) begin
      logic        s, r;
      logic [31:0] rpc;
      s   = ($urandom_range(4, 0) == 0);
      r   = ($urandom_range(7, 0) == 0);
      rpc = ($urandom_range(70, 0) << 2) | $urandom_range(3, 0);
      drive(s, r, rpc);
      model_edge(s, r, rpc);
      step();
      check("sb", observed(), exp_q.pop_front());
    end
    drive(1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives the word address into the asynchronous-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles load-use stalls, branch/jump redirects (squash), and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_DEPTH, 64, number of 32-bit words in the instruction memory; word indices >= IMEM_DEPTH are out of range.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted into IF/ID.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard-unit hold; freezes PC and IF/ID
- redirect  in  1  branch taken or jump resolved downstream
- redirect_pc  in  32  byte target address for redirect
- imem_addr  out  32  word index to instruction memory = {2'b00, pc[31:2]}
- imem_instr  in  32  instruction returned combinationally for imem_addr
- pc  out  32  current PC, byte address
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  32  IF/ID PC of that instruction
- ifid_npc  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_fault  out  1  high while the FSM is in FAULT

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC & ~3
  - ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_npc = 0, ifid_valid = 0
  - fetch_fault = 0, state = RUN
- Addressing:
  - PC is a byte address and always word-aligned.
  - redirect_pc[1:0] is forced to 0 on load.
  - imem_addr is combinational from pc.
  - in_range = (pc[31:2] < IMEM_DEPTH).
- Memory latency: 0 cycles. The IF/ID register makes the stage 1 cycle.
- FSM states:
  - RUN: normal fetch.
  - FAULT: PC out of range; fetch suspended.
- Priority at each rising edge, highest first:
  1. redirect=1:
     - pc <= {redirect_pc[31:2], 2'b00}.
     - IF/ID <= bubble (instr = NOP_INSTR, valid = 0, pc/npc = 0).
     - state <= RUN.
     - Redirect overrides a simultaneous stall.
  2. stall=1: pc, IF/ID and state hold.
  3. state=FAULT: pc holds; IF/ID <= bubble.
  4. RUN and !in_range: state <= FAULT; pc holds; IF/ID <= bubble.
  5. RUN and in_range:
     - ifid_instr <= imem_instr, ifid_pc <= pc, ifid_npc <= pc+4, ifid_valid <= 1.
     - pc <= pc+4.
- fetch_fault = (state == FAULT), registered.
- Arithmetic: pc+4 is a 32-bit modulo add. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag (range check then faults unless IMEM_DEPTH covers it).
- A redirect to an out-of-range target enters RUN first, then FAULT on the next edge. The redirect cycle itself still inserts a bubble.
- Reset assertion mid-operation immediately forces all reset values, independent of clk. Deassertion resumes fetch at RESET_PC on the next edge.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_fetches[31:0] and stat_bubbles[31:0], both reset to 0, wrapping at 2^32.
  - stat_fetches increments on every rule-5 edge.
  - stat_bubbles increments on every edge that loads a bubble (rules 1, 3, 4); stall edges count as neither.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package if_pkg: NOP_INSTR default, FSM state encoding (RUN=1'b0, FAULT=1'b1), IF/ID bundle width constant (97 bits).
- Sub-module ifid_reg: holds the IF/ID bundle, with inputs load, bubble and hold; reset to the bubble value.
- PC, FSM and counters stay in the top level.

Test Plan:
- Reset, RESET_PC=0, imem words 0..3 = 0x20010005, 0x20020007, 0x00221820, 0xAC030000, no stall:
  - After 1 edge: ifid_instr=0x20010005, ifid_pc=0, ifid_npc=4, valid=1, pc=4.
  - After 4 edges: pc=0x10.
- stall=1 for 2 cycles at pc=8: pc stays 8 and IF/ID stays constant. After release, ifid_instr=0x00221820.
- redirect=1 with redirect_pc=0x0000_0013 and stall=1 in the same cycle:
  - pc=0x10, ifid_valid=0, ifid_instr=0.
  - Next edge fetches word 4.
- Walk to pc=0x100 (word 64, IMEM_DEPTH=64):
  - 1 edge later: fetch_fault=1, pc=0x100, valid=0.
  - Stays there for 5 edges.
  - redirect to 0x8 clears the fault, and the next fetch is word 2.
- Assert rst_n=0 between clock edges mid-stream: pc=0, valid=0 and fault=0 immediately, before the next edge.
- With IF_FETCH_STATS_EN: 10 normal fetches, 1 redirect, 2 stalls give stat_fetches=10, stat_bubbles=1.
